// File: rtl/data_c_pkt_route_s2m.sv
// Packet-aware 1-to-NUM valid/ready demux. The destination is sampled on a packet's first beat.
// Packets with an out-of-range destination are swallowed whole and counted in drop_cnt.
module data_c_pkt_route_s2m #(
  parameter int unsigned NUM   = 8,
  parameter int unsigned DSIZE = 9,
  parameter int unsigned IDX_W = (NUM > 2) ? $clog2(NUM) : 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic [IDX_W-1:0] s_sel,
  output logic [NUM-1:0]   m_valid,
  input  logic [NUM-1:0]   m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned DST_N = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e             state_q;
  logic               reg_valid_q;
  logic [IDX_W-1:0]   reg_dst_q;
  logic [DSIZE-1:0]   reg_data_q;
  logic [15:0]        drop_cnt_q;
  logic [15:0]        drop_cnt_d;

  logic [DST_N-1:0]   m_ready_pad;
  logic               drain;
  logic               accept;
  logic               s_last;
  logic               sel_ok;
  logic               load;
  logic               drop_first;

  // Pad ready out to the full index range so reg_dst_q can always index it.
  assign m_ready_pad = DST_N'(m_ready);

  assign drain  = reg_valid_q && m_ready_pad[reg_dst_q];
  assign s_last = s_data[DSIZE-1];
  assign sel_ok = ({1'b0, s_sel} < (IDX_W+1)'(NUM));

  // Ready depends only on registered state and m_ready, never on s_valid/s_sel.
  assign s_ready = !rst && ((state_q == S_DROP) || !reg_valid_q || m_ready_pad[reg_dst_q]);
  assign accept  = s_valid && s_ready;

  assign load       = accept && (((state_q == S_IDLE) && sel_ok) || (state_q == S_PKT));
  assign drop_first = accept && (state_q == S_IDLE) && !sel_ok;
  assign drop_cnt_d = (drop_first && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  always_comb begin
    m_valid = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      m_valid[i] = reg_valid_q && (reg_dst_q == IDX_W'(i));
    end
  end

  assign m_data   = reg_data_q;
  assign drop_cnt = drop_cnt_q;

  // Output register, packet FSM and drop counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      reg_valid_q <= 1'b0;
      reg_dst_q   <= '0;
      reg_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;

      if (load) begin
        reg_valid_q <= 1'b1;
        reg_data_q  <= s_data;
        if (state_q == S_IDLE) begin
          reg_dst_q <= s_sel;
        end
      end else if (drain) begin
        reg_valid_q <= 1'b0;
      end

      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (!s_last) begin
              state_q <= sel_ok ? S_PKT : S_DROP;
            end
          end
          S_PKT, S_DROP: begin
            if (s_last) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_c_pkt_route_s2m.sv
// Directed bench for data_c_pkt_route_s2m: one NUM=8 instance and one NUM=6 instance for the drop path.
module tb_data_c_pkt_route_s2m;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  always #5 clock = ~clock;

  // NUM=8 instance
  logic       s_valid8 = 1'b0;
  logic       s_ready8;
  logic [8:0] s_data8 = '0;
  logic [2:0] s_sel8 = '0;
  logic [7:0] m_valid8;
  logic [7:0] m_ready8 = 8'hFF;
  logic [8:0] m_data8;
  logic [15:0] drop8;

  // NUM=6 instance
  logic       s_valid6 = 1'b0;
  logic       s_ready6;
  logic [8:0] s_data6 = '0;
  logic [2:0] s_sel6 = '0;
  logic [5:0] m_valid6;
  logic [5:0] m_ready6 = 6'h3F;
  logic [8:0] m_data6;
  logic [15:0] drop6;

  data_c_pkt_route_s2m #(.NUM(8), .DSIZE(9), .IDX_W(3)) u_dut8 (
    .clock(clock), .rst(rst),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_sel(s_sel8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .drop_cnt(drop8)
  );

  data_c_pkt_route_s2m #(.NUM(6), .DSIZE(9), .IDX_W(3)) u_dut6 (
    .clock(clock), .rst(rst),
    .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6), .s_sel(s_sel6),
    .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6), .drop_cnt(drop6)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: records handshakes that will complete on the next posedge.
  int cyc = 0;
  int onehot_viol = 0;
  int dq_dst[$];
  int dq_data[$];
  int dq_cyc[$];
  int aq_cyc[$];
  int d6_dst[$];
  int d6_data[$];

  always @(negedge clock) begin
    cyc++;
    if (!$onehot0(m_valid8) || !$onehot0(m_valid6)) onehot_viol++;
    if (s_valid8 && s_ready8) aq_cyc.push_back(cyc);
    for (int i = 0; i < 8; i++) begin
      if (m_valid8[i] && m_ready8[i]) begin
        dq_dst.push_back(i);
        dq_data.push_back(int'(m_data8));
        dq_cyc.push_back(cyc);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (m_valid6[i] && m_ready6[i]) begin
        d6_dst.push_back(i);
        d6_data.push_back(int'(m_data6));
      end
    end
  end

  task automatic clear_q();
    dq_dst.delete(); dq_data.delete(); dq_cyc.delete(); aq_cyc.delete();
    d6_dst.delete(); d6_data.delete();
  endtask

  // Offer one beat on the NUM=8 port and return just after it is accepted (s_valid left high).
  task automatic beat8(input logic [2:0] sel, input logic [8:0] data);
    int n;
    n = 0;
    s_valid8 = 1'b1;
    s_sel8   = sel;
    s_data8  = data;
    @(negedge clock);
    while (!s_ready8 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("s_ready8_wait", 32'(s_ready8), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic beat6(input logic [2:0] sel, input logic [8:0] data);
    int n;
    n = 0;
    s_valid6 = 1'b1;
    s_sel6   = sel;
    s_data6  = data;
    @(negedge clock);
    while (!s_ready6 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("s_ready6_wait", 32'(s_ready6), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid8 = 1'b0;
    s_valid6 = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect8(input string t, input int k, input int dst, input int data);
    if (k < dq_dst.size()) begin
      check($sformatf("%s_dst%0d", t, k), 32'(dq_dst[k]), 32'(dst));
      check($sformatf("%s_data%0d", t, k), 32'(dq_data[k]), 32'(data));
    end else begin
      check($sformatf("%s_count", t), 32'(dq_dst.size()), 32'(k + 1));
    end
  endtask

  task automatic expect_consec(input string t, input int n);
    for (int k = 1; k < n; k++) begin
      if (k < dq_cyc.size())
        check($sformatf("%s_gap%0d", t, k), 32'(dq_cyc[k] - dq_cyc[0]), 32'(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clock);
    check("rst_m_valid8", 32'(m_valid8), 32'h0);
    check("rst_m_data8", 32'(m_data8), 32'h0);
    check("rst_drop8", 32'(drop8), 32'h0);
    check("rst_s_ready8", 32'(s_ready8), 32'h0);
    check("rst_s_ready6", 32'(s_ready6), 32'h0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: 4-beat packet to ch3
    clear_q();
    beat8(3'd3, 9'h010);
    beat8(3'd3, 9'h011);
    beat8(3'd3, 9'h012);
    beat8(3'd3, 9'h113);
    idle(3);
    check("t1_count", 32'(dq_dst.size()), 32'd4);
    expect8("t1", 0, 3, 'h010);
    expect8("t1", 1, 3, 'h011);
    expect8("t1", 2, 3, 'h012);
    expect8("t1", 3, 3, 'h113);
    expect_consec("t1", 4);
    if (dq_cyc.size() > 0 && aq_cyc.size() > 0)
      check("t1_latency", 32'(dq_cyc[0] - aq_cyc[0]), 32'd1);

    // 2: s_sel changes mid-packet, routing must stay on ch2
    clear_q();
    beat8(3'd2, 9'h020);
    beat8(3'd2, 9'h021);
    beat8(3'd6, 9'h022);
    beat8(3'd6, 9'h023);
    beat8(3'd6, 9'h124);
    idle(3);
    check("t2_count", 32'(dq_dst.size()), 32'd5);
    for (int k = 0; k < 5; k++) expect8("t2", k, 2, (k == 4) ? 'h124 : ('h020 + k));

    // 3: back-pressure on ch1 for 10 cycles
    clear_q();
    m_ready8 = 8'hFD;
    beat8(3'd1, 9'h030);
    s_data8 = 9'h031;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check($sformatf("t3_m_valid_c%0d", c), 32'(m_valid8), 32'h02);
      check($sformatf("t3_m_data_c%0d", c), 32'(m_data8), 32'h030);
      check($sformatf("t3_s_ready_c%0d", c), 32'(s_ready8), 32'h0);
    end
    @(posedge clock);
    #1;
    m_ready8 = 8'hFF;
    beat8(3'd1, 9'h031);
    beat8(3'd1, 9'h132);
    idle(3);
    check("t3_count", 32'(dq_dst.size()), 32'd3);
    expect8("t3", 0, 1, 'h030);
    expect8("t3", 1, 1, 'h031);
    expect8("t3", 2, 1, 'h132);

    // 4: NUM=6, packet to s_sel=7 dropped whole, next packet to ch0 intact
    clear_q();
    check("t4_drop_before", 32'(drop6), 32'd0);
    s_valid6 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_sel6  = 3'd7;
      s_data6 = (b == 2) ? 9'h142 : 9'(9'h040 + b);
      @(negedge clock);
      check($sformatf("t4_s_ready_b%0d", b), 32'(s_ready6), 32'd1);
      @(posedge clock);
      #1;
    end
    idle(2);
    check("t4_no_valid", 32'(d6_dst.size()), 32'd0);
    check("t4_drop_after", 32'(drop6), 32'd1);
    beat6(3'd0, 9'h050);
    beat6(3'd0, 9'h151);
    idle(3);
    check("t4_ch0_count", 32'(d6_dst.size()), 32'd2);
    if (d6_dst.size() == 2) begin
      check("t4_ch0_dst0", 32'(d6_dst[0]), 32'd0);
      check("t4_ch0_data0", 32'(d6_data[0]), 32'h050);
      check("t4_ch0_dst1", 32'(d6_dst[1]), 32'd0);
      check("t4_ch0_data1", 32'(d6_data[1]), 32'h151);
    end
    check("t4_drop_final", 32'(drop6), 32'd1);

    // 5: eight back-to-back single-beat packets walking ch0..ch7
    clear_q();
    for (int i = 0; i < 8; i++) beat8(3'(i), 9'(9'h160 + i));
    idle(3);
    check("t5_count", 32'(dq_dst.size()), 32'd8);
    for (int i = 0; i < 8; i++) expect8("t5", i, i, 'h160 + i);
    expect_consec("t5", 8);
    for (int k = 1; k < 8; k++) begin
      if (k < aq_cyc.size())
        check($sformatf("t5_acc_gap%0d", k), 32'(aq_cyc[k] - aq_cyc[0]), 32'(k));
    end

    // 6: reset during beat 2 of a packet to ch5, then re-route to ch4
    beat8(3'd5, 9'h070);
    s_data8 = 9'h071;
    rst = 1'b1;
    clear_q();
    @(negedge clock);
    check("t6_rst_m_valid", 32'(m_valid8), 32'h0);
    check("t6_rst_drop", 32'(drop8), 32'h0);
    check("t6_rst_s_ready", 32'(s_ready8), 32'h0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    beat8(3'd4, 9'h080);
    beat8(3'd5, 9'h181);
    idle(3);
    check("t6_count", 32'(dq_dst.size()), 32'd2);
    expect8("t6", 0, 4, 'h080);
    expect8("t6", 1, 4, 'h181);

    check("onehot_m_valid", 32'(onehot_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
